// File: rtl/enc_pkg.sv
// Shared defaults and direction encodings for the encoder speed measurement block.
package enc_pkg;

    localparam int GATE_CYCLES_DEF  = 80000;
    localparam int CNT_W_DEF        = 16;
    localparam int PER_W_DEF        = 24;
    localparam int STALL_CYCLES_DEF = 8000000;

    // Window count limits for the default count width
    localparam int VEL_MAX = (1 << (CNT_W_DEF - 1)) - 1;
    localparam int VEL_MIN = -(1 << (CNT_W_DEF - 1));

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/encoder_period_meas.sv
// T-method path: cycles between same-direction pulses, reversal and stall detection.
module encoder_period_meas
    import enc_pkg::*;
#(
    parameter int PER_W        = PER_W_DEF,
    parameter int STALL_CYCLES = STALL_CYCLES_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_ni,
    input  logic             en_i,
    input  logic             dir_i,
    output logic [PER_W-1:0] period_o,
    output logic             period_dir_o,
    output logic             period_valid_o,
    output logic             reverse_o,
    output logic             stalled_o
);

    localparam logic [PER_W-1:0] STALL_LIM = PER_W'(STALL_CYCLES);

    logic [PER_W-1:0] per_cnt_q;
    logic [PER_W-1:0] period_q;
    logic             armed_q;
    logic             last_dir_q;
    logic             period_dir_q;
    logic             period_valid_q;
    logic             reverse_q;
    logic             stalled_q;
    logic             at_limit_d;

    assign at_limit_d = (per_cnt_q == STALL_LIM);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            per_cnt_q      <= '0;
            period_q       <= '0;
            armed_q        <= 1'b0;
            last_dir_q     <= 1'b0;
            period_dir_q   <= 1'b0;
            period_valid_q <= 1'b0;
            reverse_q      <= 1'b0;
            stalled_q      <= 1'b0;
        end else if (!clr_ni) begin
            per_cnt_q      <= '0;
            period_q       <= '0;
            armed_q        <= 1'b0;
            last_dir_q     <= 1'b0;
            period_dir_q   <= 1'b0;
            period_valid_q <= 1'b0;
            reverse_q      <= 1'b0;
            stalled_q      <= 1'b0;
        end else begin
            period_valid_q <= 1'b0;
            reverse_q      <= 1'b0;
            if (en_i) begin
                // A pulse always wins over the stall limit, even on the limit cycle
                per_cnt_q <= '0;
                stalled_q <= 1'b0;
                if (!armed_q) begin
                    armed_q    <= 1'b1;
                    last_dir_q <= dir_i;
                end else if (dir_i == last_dir_q) begin
                    period_q       <= per_cnt_q + PER_W'(1);
                    period_dir_q   <= dir_i;
                    period_valid_q <= 1'b1;
                end else begin
                    reverse_q  <= 1'b1;
                    last_dir_q <= dir_i;
                end
            end else if (at_limit_d) begin
                stalled_q <= 1'b1;
                armed_q   <= 1'b0;
            end else begin
                per_cnt_q <= per_cnt_q + PER_W'(1);
            end
        end
    end

    assign period_o       = period_q;
    assign period_dir_o   = period_dir_q;
    assign period_valid_o = period_valid_q;
    assign reverse_o      = reverse_q;
    assign stalled_o      = stalled_q;

endmodule

// File: rtl/encoder_speed_meas.sv
// M-method gate-window pulse counter plus the T-method period path.
module encoder_speed_meas
    import enc_pkg::*;
#(
    parameter int GATE_CYCLES  = GATE_CYCLES_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int PER_W        = PER_W_DEF,
    parameter int STALL_CYCLES = STALL_CYCLES_DEF
) (
    input  logic             clk80m,
    input  logic             reset,
    input  logic             enc_rstn,
    input  logic             count_enable,
    input  logic             count_direction,
    output logic [CNT_W-1:0] vel_count,
    output logic             vel_valid,
    output logic [PER_W-1:0] period,
    output logic             period_dir,
    output logic             period_valid,
    output logic             reverse,
    output logic             stalled
);

    localparam int GATE_W = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};

    logic [GATE_W-1:0] gate_cnt_q;
    logic [CNT_W-1:0]  acc_q;
    logic [CNT_W-1:0]  vel_count_q;
    logic              vel_valid_q;
    logic [CNT_W:0]    step_d;
    logic [CNT_W:0]    sum_d;
    logic [CNT_W-1:0]  acc_sat_d;

    // vel_valid / period_valid are single-cycle strobes: the data output is
    // stable from the strobe cycle until the next strobe, with no back-pressure.
    always_comb begin
        step_d = '0;
        if (count_enable) begin
            step_d = (count_direction == DIR_UP) ? (CNT_W+1)'(1) : '1;
        end
        sum_d     = {acc_q[CNT_W-1], acc_q} + step_d;
        acc_sat_d = sum_d[CNT_W-1:0];
        if (sum_d[CNT_W] != sum_d[CNT_W-1]) begin
            acc_sat_d = sum_d[CNT_W] ? CNT_MIN : CNT_MAX;
        end
    end

    always_ff @(posedge clk80m or posedge reset) begin
        if (reset) begin
            gate_cnt_q  <= '0;
            acc_q       <= '0;
            vel_count_q <= '0;
            vel_valid_q <= 1'b0;
        end else if (!enc_rstn) begin
            gate_cnt_q  <= '0;
            acc_q       <= '0;
            vel_count_q <= '0;
            vel_valid_q <= 1'b0;
        end else begin
            vel_valid_q <= 1'b0;
            if (gate_cnt_q == GATE_LAST) begin
                // The pulse on the terminal cycle closes out this window
                gate_cnt_q  <= '0;
                acc_q       <= '0;
                vel_count_q <= acc_sat_d;
                vel_valid_q <= 1'b1;
            end else begin
                gate_cnt_q <= gate_cnt_q + GATE_W'(1);
                acc_q      <= acc_sat_d;
            end
        end
    end

    assign vel_count = vel_count_q;
    assign vel_valid = vel_valid_q;

    encoder_period_meas #(
        .PER_W        (PER_W),
        .STALL_CYCLES (STALL_CYCLES)
    ) u_period (
        .clk_i          (clk80m),
        .rst_i          (reset),
        .clr_ni         (enc_rstn),
        .en_i           (count_enable),
        .dir_i          (count_direction),
        .period_o       (period),
        .period_dir_o   (period_dir),
        .period_valid_o (period_valid),
        .reverse_o      (reverse),
        .stalled_o      (stalled)
    );

endmodule

// File: tb/tb_encoder_speed_meas.sv
// Bench for encoder_speed_meas: two instances (100- and 200-cycle gates) share one stimulus stream.
module tb_encoder_speed_meas;

    localparam int CNT_W = 8;
    localparam int PER_W = 24;
    localparam int STALL = 1000;
    localparam int GA    = 100;
    localparam int GB    = 200;

    // clock / reset
    logic clk80m = 1'b0;
    logic reset = 1'b1;
    logic enc_rstn = 1'b1;
    logic count_enable = 1'b0;
    logic count_direction = 1'b0;

    always #5 clk80m = ~clk80m;

    logic [CNT_W-1:0] vel_count_a, vel_count_b;
    logic             vel_valid_a, vel_valid_b;
    logic [PER_W-1:0] period_a, period_b;
    logic             period_dir_a, period_dir_b;
    logic             period_valid_a, period_valid_b;
    logic             reverse_a, reverse_b;
    logic             stalled_a, stalled_b;

    encoder_speed_meas #(.GATE_CYCLES(GA), .CNT_W(CNT_W), .PER_W(PER_W), .STALL_CYCLES(STALL)) dut_a (
        .clk80m(clk80m), .reset(reset), .enc_rstn(enc_rstn),
        .count_enable(count_enable), .count_direction(count_direction),
        .vel_count(vel_count_a), .vel_valid(vel_valid_a),
        .period(period_a), .period_dir(period_dir_a), .period_valid(period_valid_a),
        .reverse(reverse_a), .stalled(stalled_a)
    );

    encoder_speed_meas #(.GATE_CYCLES(GB), .CNT_W(CNT_W), .PER_W(PER_W), .STALL_CYCLES(STALL)) dut_b (
        .clk80m(clk80m), .reset(reset), .enc_rstn(enc_rstn),
        .count_enable(count_enable), .count_direction(count_direction),
        .vel_count(vel_count_b), .vel_valid(vel_valid_b),
        .period(period_b), .period_dir(period_dir_b), .period_valid(period_valid_b),
        .reverse(reverse_b), .stalled(stalled_b)
    );

    // scoreboard
    int n_total = 0;
    int n_bad = 0;
    logic [CNT_W-1:0] vel_q_a[$];
    logic [CNT_W-1:0] vel_q_b[$];
    logic [PER_W:0]   per_q_a[$];
    logic [PER_W:0]   per_q_b[$];
    int acc_m[2];
    int gate_m[2] = '{GA, GB};
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic int sat8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    always @(negedge clk80m) begin
        if (vel_valid_a) begin
            check("vel_a_pending", 32'(vel_q_a.size() != 0), 32'd1);
            if (vel_q_a.size() != 0) check("vel_a", 32'(vel_count_a), 32'(vel_q_a.pop_front()));
        end
        if (vel_valid_b) begin
            check("vel_b_pending", 32'(vel_q_b.size() != 0), 32'd1);
            if (vel_q_b.size() != 0) check("vel_b", 32'(vel_count_b), 32'(vel_q_b.pop_front()));
        end
        if (period_valid_a) begin
            check("per_a_pending", 32'(per_q_a.size() != 0), 32'd1);
            if (per_q_a.size() != 0) check("period_a", 32'({period_dir_a, period_a}), 32'(per_q_a.pop_front()));
        end
        if (period_valid_b) begin
            check("per_b_pending", 32'(per_q_b.size() != 0), 32'd1);
            if (per_q_b.size() != 0) check("period_b", 32'({period_dir_b, period_b}), 32'(per_q_b.pop_front()));
        end
    end

    // driver tasks
    task automatic step(input logic en, input logic dir);
        int d;
        count_enable = en;
        count_direction = dir;
        @(posedge clk80m);
        #1;
        d = en ? (dir ? 1 : -1) : 0;
        for (int i = 0; i < 2; i++) begin
            acc_m[i] = sat8(acc_m[i] + d);
            if (cyc % gate_m[i] == gate_m[i] - 1) begin
                if (i == 0) vel_q_a.push_back(CNT_W'(acc_m[i]));
                else        vel_q_b.push_back(CNT_W'(acc_m[i]));
                acc_m[i] = 0;
            end
        end
        cyc++;
        count_enable = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic pulse(input logic dir);
        step(1'b1, dir);
    endtask

    task automatic exp_per(input int p, input logic dir);
        per_q_a.push_back({dir, PER_W'(p)});
        per_q_b.push_back({dir, PER_W'(p)});
    endtask

    task automatic do_reset(input bit use_rstn);
        @(negedge clk80m);
        #1;
        count_enable = 1'b0;
        if (use_rstn) enc_rstn = 1'b0;
        else reset = 1'b1;
        repeat (3) @(posedge clk80m);
        #1;
        check("rst_vel_a", 32'(vel_count_a), 32'd0);
        check("rst_vel_b", 32'(vel_count_b), 32'd0);
        check("rst_vv_a", 32'(vel_valid_a), 32'd0);
        check("rst_period_a", 32'({period_dir_a, period_a}), 32'd0);
        check("rst_period_b", 32'({period_dir_b, period_b}), 32'd0);
        check("rst_pv_a", 32'(period_valid_a), 32'd0);
        check("rst_rev_a", 32'(reverse_a), 32'd0);
        check("rst_stall_a", 32'(stalled_a), 32'd0);
        check("rst_vq_empty", 32'(vel_q_a.size() + vel_q_b.size()), 32'd0);
        check("rst_pq_empty", 32'(per_q_a.size() + per_q_b.size()), 32'd0);
        vel_q_a.delete();
        vel_q_b.delete();
        per_q_a.delete();
        per_q_b.delete();
        acc_m = '{0, 0};
        cyc = 0;
        reset = 1'b0;
        enc_rstn = 1'b1;
    endtask

    initial begin
        do_reset(1'b0);

        // 10 up-pulses spaced 10 in window 0 of dut_a, then an empty window
        for (int k = 0; k < 10; k++) begin
            if (k > 0) exp_per(10, 1'b1);
            pulse(1'b1);
            idle(9);
        end
        check("win_10", 32'(vel_count_a), 32'd10);
        idle(100);
        check("win_empty", 32'(vel_count_a), 32'd0);
        check("win_b_10", 32'(vel_count_b), 32'd10);

        // period 25, first pulse only arms
        do_reset(1'b0);
        pulse(1'b1);
        for (int k = 0; k < 3; k++) begin
            idle(24);
            exp_per(25, 1'b1);
            pulse(1'b1);
        end
        check("period_hold", 32'(period_a), 32'd25);

        // up, up, down reversal then down period 30
        do_reset(1'b0);
        pulse(1'b1);
        idle(19);
        exp_per(20, 1'b1);
        pulse(1'b1);
        idle(19);
        pulse(1'b0);
        check("reverse_a", 32'(reverse_a), 32'd1);
        check("reverse_b", 32'(reverse_b), 32'd1);
        idle(1);
        check("reverse_once", 32'(reverse_a), 32'd0);
        idle(28);
        exp_per(30, 1'b0);
        pulse(1'b0);
        idle(2);
        check("period_dir_dn", 32'(period_dir_a), 32'd0);

        // stall boundary and release
        do_reset(1'b0);
        pulse(1'b1);
        idle(STALL);
        check("stall_not_yet", 32'(stalled_a), 32'd0);
        idle(1);
        check("stall_set", 32'(stalled_a), 32'd1);
        check("stall_set_b", 32'(stalled_b), 32'd1);
        pulse(1'b1);
        check("stall_clear", 32'(stalled_a), 32'd0);
        idle(4);
        exp_per(5, 1'b1);
        pulse(1'b1);
        idle(3);

        // saturation up then down, back-to-back pulses give period 1
        do_reset(1'b0);
        for (int k = 0; k < 130; k++) begin
            if (k > 0) exp_per(1, 1'b1);
            pulse(1'b1);
        end
        idle(GB - 130);
        check("sat_up_b", 32'(vel_count_b), 32'h7f);
        check("sat_up_a", 32'(vel_count_a), 32'd30);
        do_reset(1'b0);
        for (int k = 0; k < 130; k++) begin
            if (k > 0) exp_per(1, 1'b0);
            pulse(1'b0);
        end
        idle(GB - 130);
        check("sat_dn_b", 32'(vel_count_b), 32'h80);
        check("sat_dn_a", 32'(vel_count_a), 32'he2);

        // mid-window reset via reset, then via enc_rstn
        for (int r = 0; r < 2; r++) begin
            do_reset(1'b0);
            for (int k = 0; k < 5; k++) begin
                if (k > 0) exp_per(10, 1'b1);
                pulse(1'b1);
                idle(9);
            end
            do_reset(r == 1);
            for (int k = 0; k < 3; k++) begin
                if (k > 0) exp_per(10, 1'b1);
                pulse(1'b1);
                idle(9);
            end
            idle(GA - 30);
            check("post_rst_win", 32'(vel_count_a), 32'd3);
        end

        idle(5);
        check("end_vq_a", 32'(vel_q_a.size()), 32'd0);
        check("end_vq_b", 32'(vel_q_b.size()), 32'd0);
        check("end_pq_a", 32'(per_q_a.size()), 32'd0);
        check("end_pq_b", 32'(per_q_b.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
